// File: rtl/ahbl_excl_monitor_if.sv
// Bus bundle for the AHB-Lite exclusive-access monitor.
// Carries the upstream side (s_*, facing the arbiter's slave-side port) and the
// downstream side (m_*, facing the shared slave) as one connection.
//   slave  modport : view of the monitor itself (takes requests on s_*, drives m_*)
//   master modport : view of the surrounding fabric (arbiter + slave), directions reversed
// Parameters: W_ADDR address width, W_DATA data width.
interface ahbl_excl_monitor_if #(
   parameter int unsigned W_ADDR = 32,
   parameter int unsigned W_DATA = 32
);
   // upstream (arbiter side)
   logic              s_hready;
   logic              s_hready_resp;
   logic              s_hresp;
   logic [W_ADDR-1:0] s_haddr;
   logic              s_hwrite;
   logic [1:0]        s_htrans;
   logic [2:0]        s_hsize;
   logic [W_DATA-1:0] s_hwdata;
   logic [W_DATA-1:0] s_hrdata;
   logic              s_hexcl;
   logic [7:0]        s_hmaster;
   logic              s_hexokay;
   // downstream (shared slave side)
   logic              m_hready;
   logic              m_hready_resp;
   logic              m_hresp;
   logic [W_ADDR-1:0] m_haddr;
   logic              m_hwrite;
   logic [1:0]        m_htrans;
   logic [2:0]        m_hsize;
   logic [W_DATA-1:0] m_hwdata;
   logic [W_DATA-1:0] m_hrdata;

   modport slave (
      input  s_hready, s_haddr, s_hwrite, s_htrans, s_hsize, s_hwdata, s_hexcl, s_hmaster,
      input  m_hready_resp, m_hresp, m_hrdata,
      output s_hready_resp, s_hresp, s_hrdata, s_hexokay,
      output m_hready, m_haddr, m_hwrite, m_htrans, m_hsize, m_hwdata
   );

   modport master (
      output s_hready, s_haddr, s_hwrite, s_htrans, s_hsize, s_hwdata, s_hexcl, s_hmaster,
      output m_hready_resp, m_hresp, m_hrdata,
      input  s_hready_resp, s_hresp, s_hrdata, s_hexokay,
      input  m_hready, m_haddr, m_hwrite, m_htrans, m_hsize, m_hwdata
   );
endinterface

// File: rtl/ahbl_excl_monitor.sv
// Global exclusive-access monitor placed between an N:1 AHB-Lite arbiter and one
// shared slave. Holds one reservation granule per master (indexed by hmaster),
// produces hexokay in the data phase, and turns failing exclusive stores into
// IDLE cycles so they never reach the slave.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    ahbl_excl_monitor_if.slave: upstream s_* request/response and
//          downstream m_* pass-through (m_htrans forced IDLE for a failed store)
module ahbl_excl_monitor #(
   parameter int unsigned N_MASTERS    = 2,
   parameter int unsigned W_ADDR       = 32,
   parameter int unsigned W_DATA       = 32,
   parameter int unsigned GRANULE_LOG2 = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ahbl_excl_monitor_if.slave     bus
);

   localparam int unsigned W_GRAN = W_ADDR - GRANULE_LOG2;
   typedef logic [W_GRAN-1:0] gran_t;

   // reservations
   logic [N_MASTERS-1:0] resv_valid_q, resv_valid_d;
   gran_t                resv_gran_q [N_MASTERS];
   gran_t                resv_gran_d [N_MASTERS];

   // data-phase control captured at address-phase acceptance
   logic       dph_valid_q, dph_valid_d;
   logic       dph_excl_q,  dph_excl_d;
   logic       dph_write_q, dph_write_d;
   logic       dph_supp_q,  dph_supp_d;
   logic [7:0] dph_mst_q,   dph_mst_d;
   gran_t      dph_gran_q,  dph_gran_d;

   gran_t             addr_gran;
   logic              addr_accept;
   logic              dph_live;
   logic              dph_done;
   logic              excl_pass;
   logic              store_supp;
   logic [W_DATA-1:0] rdata;

   assign addr_gran   = bus.s_haddr[W_ADDR-1:GRANULE_LOG2];
   assign addr_accept = bus.s_hready & bus.s_htrans[1];

   // A suppressed store's data phase is answered locally; the slave is ignored.
   assign dph_live          = dph_valid_q & ~dph_supp_q;
   assign bus.s_hready_resp = dph_live ? bus.m_hready_resp : 1'b1;
   assign bus.s_hresp       = dph_live & bus.m_hresp;
   assign bus.s_hexokay     = dph_live & dph_excl_q & bus.m_hready_resp & ~bus.m_hresp;
   assign dph_done          = dph_valid_q & bus.s_hready_resp;

   // downstream pass-through
   assign rdata        = bus.m_hrdata;
   assign bus.s_hrdata = rdata;
   assign bus.m_hready = bus.s_hready;
   assign bus.m_haddr  = bus.s_haddr;
   assign bus.m_hwrite = bus.s_hwrite;
   assign bus.m_hsize  = bus.s_hsize;
   assign bus.m_hwdata = bus.s_hwdata;
   assign bus.m_htrans = store_supp ? 2'b00 : bus.s_htrans;

   // Reservation update when the current data phase completes.
   always_comb begin
      resv_valid_d = resv_valid_q;
      resv_gran_d  = resv_gran_q;
      if (dph_done) begin
         for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (dph_supp_q) begin
               if (dph_mst_q == 8'(i)) resv_valid_d[i] = 1'b0;
            end else if (dph_write_q) begin
               // any performed write kills matching granules, erroring or not
               if ((dph_mst_q == 8'(i)) || (resv_gran_q[i] == dph_gran_q)) begin
                  resv_valid_d[i] = 1'b0;
               end
            end else if (dph_excl_q && !bus.m_hresp && (dph_mst_q == 8'(i))) begin
               resv_valid_d[i] = 1'b1;
               resv_gran_d[i]  = dph_gran_q;
            end
         end
      end
   end

   // Store check sees the reservation as updated by a data phase completing in
   // the same cycle, so back-to-back LDREX/STREX works.
   always_comb begin
      excl_pass = 1'b0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         if ((bus.s_hmaster == 8'(i)) && resv_valid_d[i] && (resv_gran_d[i] == addr_gran)) begin
            excl_pass = 1'b1;
         end
      end
   end

   assign store_supp = addr_accept & bus.s_hexcl & bus.s_hwrite & ~excl_pass;

   always_comb begin
      dph_valid_d = dph_valid_q;
      dph_excl_d  = dph_excl_q;
      dph_write_d = dph_write_q;
      dph_supp_d  = dph_supp_q;
      dph_mst_d   = dph_mst_q;
      dph_gran_d  = dph_gran_q;
      if (bus.s_hready) begin
         dph_valid_d = addr_accept;
         dph_excl_d  = bus.s_hexcl;
         dph_write_d = bus.s_hwrite;
         dph_supp_d  = store_supp;
         dph_mst_d   = bus.s_hmaster;
         dph_gran_d  = addr_gran;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resv_valid_q <= '0;
         for (int unsigned i = 0; i < N_MASTERS; i++) resv_gran_q[i] <= '0;
         dph_valid_q  <= 1'b0;
         dph_excl_q   <= 1'b0;
         dph_write_q  <= 1'b0;
         dph_supp_q   <= 1'b0;
         dph_mst_q    <= '0;
         dph_gran_q   <= '0;
      end else begin
         resv_valid_q <= resv_valid_d;
         resv_gran_q  <= resv_gran_d;
         dph_valid_q  <= dph_valid_d;
         dph_excl_q   <= dph_excl_d;
         dph_write_q  <= dph_write_d;
         dph_supp_q   <= dph_supp_d;
         dph_mst_q    <= dph_mst_d;
         dph_gran_q   <= dph_gran_d;
      end
   end

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Self-checking bench for ahbl_excl_monitor: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level reservation model.
module tb_ahbl_excl_monitor;
   localparam int unsigned NM = 2;
   localparam int unsigned WA = 32;
   localparam int unsigned WD = 32;
   localparam int unsigned GL = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ahbl_excl_monitor_if #(.W_ADDR(WA), .W_DATA(WD)) bus ();
   // arbiter returns the selected slave's hreadyout as hready
   assign bus.s_hready = bus.s_hready_resp;

   ahbl_excl_monitor #(
      .N_MASTERS(NM), .W_ADDR(WA), .W_DATA(WD), .GRANULE_LOG2(GL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      int          id;
      bit          idle;
      int          mst;
      int unsigned addr;
      bit          write;
      bit          excl;
      int          waits;
      bit          err;
   } txn_t;

   txn_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   next_id = 0;

   // model: reservation table plus the transaction currently in its data phase
   bit          resv_v [NM];
   int unsigned resv_g [NM];
   bit          dp_valid = 0;
   bit          dp_supp = 0;
   int          dp_cnt = 0;
   txn_t        dp;

   bit obs_supp [int];
   bit obs_exok [int];
   bit obs_exok_any [int];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int push(int mst, int unsigned addr, bit write, bit excl,
                               int waits = 0, bit err = 0, bit idle = 0);
      txn_t t;
      t.id = next_id; next_id++;
      t.idle = idle; t.mst = mst; t.addr = addr; t.write = write; t.excl = excl;
      t.waits = waits; t.err = err;
      obs_supp[t.id] = 0; obs_exok[t.id] = 0; obs_exok_any[t.id] = 0;
      q.push_back(t);
      return t.id;
   endfunction

   function automatic int unsigned gran(int unsigned a);
      return a >> GL;
   endfunction

   function automatic bit model_pass(txn_t t);
      if (t.mst >= int'(NM)) return 0;
      return resv_v[t.mst] && (resv_g[t.mst] == gran(t.addr));
   endfunction

   function automatic void model_complete();
      if (dp_supp) begin
         if (dp.mst < int'(NM)) resv_v[dp.mst] = 0;
      end else if (dp.write) begin
         for (int m = 0; m < int'(NM); m++) if (resv_g[m] == gran(dp.addr)) resv_v[m] = 0;
         if (dp.mst < int'(NM)) resv_v[dp.mst] = 0;
      end else if (dp.excl && !dp.err && dp.mst < int'(NM)) begin
         resv_v[dp.mst] = 1;
         resv_g[dp.mst] = gran(dp.addr);
      end
   endfunction

   function automatic void model_reset();
      for (int m = 0; m < int'(NM); m++) begin resv_v[m] = 0; resv_g[m] = 0; end
      dp_valid = 0; dp_supp = 0; dp_cnt = 0;
      q.delete();
   endfunction

   // One bus cycle: drive at negedge, compare 1 time unit later, advance model.
   task automatic step();
      txn_t       a;
      bit         have_a, rdy, rsp, mr, mresp, exok, acc, supp;
      logic [1:0] htrans;
      @(negedge clk);
      if (!dp_valid) begin rdy = 1; rsp = 0; mr = 1; mresp = 0; end
      else if (dp_supp) begin rdy = 1; rsp = 0; mr = 1'($urandom); mresp = 1'($urandom); end
      else if (dp.err) begin rdy = (dp_cnt >= 1); rsp = 1; mr = rdy; mresp = 1; end
      else begin rdy = (dp_cnt >= dp.waits); rsp = 0; mr = rdy; mresp = 0; end
      exok = dp_valid && !dp_supp && dp.excl && rdy && !rsp;
      have_a = (q.size() > 0);
      if (have_a) a = q[0];
      else a = '{id: -1, idle: 1, mst: 0, addr: 0, write: 0, excl: 0, waits: 0, err: 0};
      htrans = a.idle ? 2'b00 : 2'b10;
      bus.s_htrans      = htrans;
      bus.s_haddr       = a.addr;
      bus.s_hwrite      = a.write;
      bus.s_hexcl       = a.excl;
      bus.s_hmaster     = 8'(a.mst);
      bus.s_hsize       = 3'd2;
      bus.s_hwdata      = $urandom;
      bus.m_hready_resp = mr;
      bus.m_hresp       = mresp;
      bus.m_hrdata      = $urandom;
      if (dp_valid && rdy) model_complete();
      acc  = rdy && !a.idle;
      supp = acc && a.excl && a.write && !model_pass(a);
      #1;
      chk("s_hready_resp", 32'(bus.s_hready_resp), 32'(rdy));
      chk("s_hresp", 32'(bus.s_hresp), 32'(rsp));
      chk("s_hexokay", 32'(bus.s_hexokay), 32'(exok));
      chk("m_htrans", 32'(bus.m_htrans), supp ? 32'd0 : 32'(htrans));
      chk("m_haddr", bus.m_haddr, a.addr);
      chk("m_hwrite", 32'(bus.m_hwrite), 32'(a.write));
      chk("m_hsize", 32'(bus.m_hsize), 32'd2);
      chk("m_hwdata", bus.m_hwdata, bus.s_hwdata);
      chk("s_hrdata", bus.s_hrdata, bus.m_hrdata);
      chk("m_hready", 32'(bus.m_hready), 32'(rdy));
      if (dp_valid) begin
         if (bus.s_hexokay) obs_exok_any[dp.id] = 1;
         if (rdy) obs_exok[dp.id] = bus.s_hexokay;
      end
      if (acc) obs_supp[a.id] = (bus.m_htrans == 2'b00);
      if (rdy) begin
         if (have_a) void'(q.pop_front());
         dp_valid = acc;
         if (acc) begin dp = a; dp_supp = supp; dp_cnt = 0; end
      end else begin
         dp_cnt++;
      end
   endtask

   task automatic drain(int budget);
      int k = 0;
      while ((q.size() > 0 || dp_valid) && k < budget) begin step(); k++; end
      if (q.size() > 0 || dp_valid) begin
         n_checks++; n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete(); dp_valid = 0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, b, c, d, r, s, k;
      int unsigned bases [4];
      int          msts [5];
      bases = '{32'h100, 32'h108, 32'h200, 32'h208};
      msts  = '{0, 1, 0, 1, 5};
      model_reset();
      bus.s_htrans = 2'b00; bus.s_haddr = '0; bus.s_hwrite = 0; bus.s_hexcl = 0;
      bus.s_hmaster = '0; bus.s_hsize = 3'd2; bus.s_hwdata = '0;
      bus.m_hready_resp = 0; bus.m_hresp = 1; bus.m_hrdata = '0;
      #3;
      chk("reset_hready_resp", 32'(bus.s_hready_resp), 32'd1);
      chk("reset_hresp", 32'(bus.s_hresp), 32'd0);
      chk("reset_hexokay", 32'(bus.s_hexokay), 32'd0);
      chk("reset_m_htrans", 32'(bus.m_htrans), 32'd0);
      @(negedge clk); rst_n = 1;

      // 1: LDREX then STREX to the same 8-byte granule
      a = push(0, 32'h100, 0, 1); b = push(0, 32'h104, 1, 1); c = push(0, 32'h100, 1, 1);
      drain(50);
      chk("t1_ldrex_exokay", 32'(obs_exok[a]), 32'd1);
      chk("t1_strex_not_supp", 32'(obs_supp[b]), 32'd0);
      chk("t1_strex_exokay", 32'(obs_exok[b]), 32'd1);
      chk("t1_resv_cleared_supp", 32'(obs_supp[c]), 32'd1);

      // 2: another master's plain store breaks the reservation
      a = push(0, 32'h100, 0, 1); b = push(1, 32'h100, 1, 0); c = push(0, 32'h100, 1, 1);
      drain(50);
      chk("t2_plain_str_not_supp", 32'(obs_supp[b]), 32'd0);
      chk("t2_strex_supp", 32'(obs_supp[c]), 32'd1);
      chk("t2_strex_exokay", 32'(obs_exok[c]), 32'd0);

      // 3: competing reservations, first STREX wins
      a = push(0, 32'h200, 0, 1); b = push(1, 32'h200, 0, 1);
      c = push(1, 32'h200, 1, 1); d = push(0, 32'h200, 1, 1);
      drain(50);
      chk("t3_m1_exokay", 32'(obs_exok[c]), 32'd1);
      chk("t3_m0_supp", 32'(obs_supp[d]), 32'd1);

      // 4: back-to-back LDREX/STREX relies on forwarding
      a = push(0, 32'h300, 0, 1); b = push(0, 32'h300, 1, 1);
      drain(50);
      chk("t4_fwd_not_supp", 32'(obs_supp[b]), 32'd0);
      chk("t4_fwd_exokay", 32'(obs_exok[b]), 32'd1);

      // 5: two-cycle error on LDREX sets no reservation
      a = push(0, 32'h400, 0, 1, 0, 1); b = push(0, 32'h400, 1, 1);
      drain(50);
      chk("t5_err_exokay_any", 32'(obs_exok_any[a]), 32'd0);
      chk("t5_strex_supp", 32'(obs_supp[b]), 32'd1);

      // 6: out-of-range master, then reset in a wait state
      a = push(5, 32'h100, 1, 1);
      drain(50);
      chk("t6_m5_supp", 32'(obs_supp[a]), 32'd1);
      chk("t6_m5_exokay", 32'(obs_exok[a]), 32'd0);
      a = push(0, 32'h500, 0, 1); r = push(1, 32'h600, 0, 0, 4);
      k = 0;
      while (!(dp_valid && dp.id == r) && k < 40) begin step(); k++; end
      chk("t6_reach_wait", 32'(dp_valid && dp.id == r), 32'd1);
      step();
      bus.s_htrans = 2'b10; bus.s_hexcl = 0; bus.s_hwrite = 1; bus.s_haddr = 32'h500;
      rst_n = 0;
      #1;
      chk("t6_rst_hready_resp", 32'(bus.s_hready_resp), 32'd1);
      chk("t6_rst_hresp", 32'(bus.s_hresp), 32'd0);
      chk("t6_rst_hexokay", 32'(bus.s_hexokay), 32'd0);
      chk("t6_rst_m_htrans", 32'(bus.m_htrans), 32'h2);
      model_reset();
      @(posedge clk); @(negedge clk); rst_n = 1;
      s = push(0, 32'h500, 1, 1);
      drain(50);
      chk("t6_resv_dropped_supp", 32'(obs_supp[s]), 32'd1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         void'(push(msts[$urandom_range(0, 4)],
                    bases[$urandom_range(0, 3)] + 4 * $urandom_range(0, 1),
                    1'($urandom), ($urandom_range(0, 2) != 0),
                    $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0)));
      end
      drain(20000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
